// File: rtl/rf_scoreboard_pkg.sv
// Pipeline-wide register-file constants and writeback request types shared by
// the scoreboard and its write-port arbiter.
package rf_scoreboard_pkg;
  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xdata_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    xdata_t   data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t idx);
    logic [NUM_REGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/rf_wb_arb.sv
// Fixed-priority two-way mux onto the single regfile write port: the ALU
// always wins, the LSU is served only in otherwise idle, unstalled cycles.
module rf_wb_arb
  import rf_scoreboard_pkg::*;
(
  input  logic     pipe_stall_i,
  input  wb_req_t  alu_req_i,
  input  wb_req_t  lsu_req_i,
  output logic     lsu_ready_o,
  output logic     rf_wen_o,
  output reg_idx_t rf_wadd_o,
  output xdata_t   rf_wdata_o
);

  always_comb begin
    rf_wen_o   = 1'b0;
    rf_wadd_o  = '0;
    rf_wdata_o = '0;
    if (alu_req_i.valid) begin
      rf_wen_o   = 1'b1;
      rf_wadd_o  = alu_req_i.rd;
      rf_wdata_o = alu_req_i.data;
    end else if (lsu_req_i.valid) begin
      rf_wen_o   = 1'b1;
      rf_wadd_o  = lsu_req_i.rd;
      rf_wdata_o = lsu_req_i.data;
    end
  end

  assign lsu_ready_o = lsu_req_i.valid & ~alu_req_i.valid & ~pipe_stall_i;

endmodule

// File: rtl/rf_scoreboard.sv
// Register-file scoreboard: per-register busy tracking for RAW/WAW issue
// stalls, a cap on in-flight LSU ops, and the shared writeback port.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter int MAX_LONG = 2,
  parameter int CNT_W    = 3
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 pipe_stall,
  input  logic                 iss_valid,
  input  logic [REG_IDX_W-1:0] iss_rs1,
  input  logic [REG_IDX_W-1:0] iss_rs2,
  input  logic                 iss_use_rs1,
  input  logic                 iss_use_rs2,
  input  logic [REG_IDX_W-1:0] iss_rd,
  input  logic                 iss_rd_wen,
  input  logic                 iss_long,
  output logic                 iss_stall,
  input  logic                 alu_wb_valid,
  input  logic [REG_IDX_W-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]      alu_wb_data,
  input  logic                 lsu_wb_valid,
  input  logic [REG_IDX_W-1:0] lsu_wb_rd,
  input  logic [XLEN-1:0]      lsu_wb_data,
  output logic                 lsu_wb_ready,
  output logic                 rf_wen,
  output logic [REG_IDX_W-1:0] rf_wadd,
  output logic [XLEN-1:0]      rf_wdata,
  output logic [NUM_REGS-1:0]  busy_vec,
  output logic                 wb_err
);

  logic [NUM_REGS-1:0] busy_q, busy_d, set_vec, clr_vec;
  logic [CNT_W-1:0]    long_cnt_q, long_cnt_d;
  logic                wb_err_q, wb_err_d;
  logic                raw, waw, lim, accept, commit, lsu_commit, long_inc;

  rf_wb_arb u_arb (
    .pipe_stall_i (pipe_stall),
    .alu_req_i    ('{valid: alu_wb_valid, rd: alu_wb_rd, data: alu_wb_data}),
    .lsu_req_i    ('{valid: lsu_wb_valid, rd: lsu_wb_rd, data: lsu_wb_data}),
    .lsu_ready_o  (lsu_wb_ready),
    .rf_wen_o     (rf_wen),
    .rf_wadd_o    (rf_wadd),
    .rf_wdata_o   (rf_wdata)
  );

  // Hazards look only at registered state; a same-cycle commit does not bypass.
  assign raw       = (iss_use_rs1 & busy_q[iss_rs1]) | (iss_use_rs2 & busy_q[iss_rs2]);
  assign waw       = iss_rd_wen & busy_q[iss_rd];
  assign lim       = iss_long & (long_cnt_q == CNT_W'(MAX_LONG));
  assign iss_stall = iss_valid & (raw | waw | lim);

  assign accept     = iss_valid & ~iss_stall & ~pipe_stall;
  assign commit     = rf_wen & ~pipe_stall;
  assign lsu_commit = lsu_wb_ready;
  assign long_inc   = accept & iss_long;

  assign set_vec = (accept & iss_rd_wen) ? reg_onehot(iss_rd) : '0;
  assign clr_vec = commit ? reg_onehot(rf_wadd) : '0;

  // Set is applied after clear so a new pending writer keeps the register busy.
  assign busy_d[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
    assign busy_d[gi] = (busy_q[gi] & ~clr_vec[gi]) | set_vec[gi];
  end

  always_comb begin
    long_cnt_d = long_cnt_q;
    if (long_inc && !lsu_commit) begin
      long_cnt_d = long_cnt_q + 1'b1;
    end else if (lsu_commit && !long_inc) begin
      long_cnt_d = long_cnt_q - 1'b1;
    end
  end

  assign wb_err_d = wb_err_q | (commit & (rf_wadd != '0) & ~busy_q[rf_wadd]);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      busy_q     <= '0;
      long_cnt_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      long_cnt_q <= long_cnt_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign busy_vec = busy_q;
  assign wb_err   = wb_err_q;

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Register-file hazard controller and write-port arbiter for the integer pipeline. It tracks, per architectural register, whether a write is still outstanding and stalls issue on RAW/WAW hazards. It also shares the single register-file write port between the ALU writeback path and the load/store unit (LSU), and bounds the number of in-flight long-latency operations. It sits between decode/issue and the `regfile` write port (`wen`/`wadd`/`wdata`).

## Interface
Parameters:
- MAX_LONG, 2, maximum outstanding long-latency (LSU) ops; 1..7
- CNT_W, 3, width of the outstanding-op counter; must satisfy 2^CNT_W > MAX_LONG

Ports:
- CLK  in  1  clock
- RSTn  in  1  reset, asynchronous, active-low
- pipe_stall  in  1  global pipeline stall (same signal fed to `regfile.stall`)
- iss_valid  in  1  decode presents an instruction
- iss_rs1, iss_rs2  in  5 each  source register indices
- iss_use_rs1, iss_use_rs2  in  1 each  source is actually read
- iss_rd  in  5  destination index
- iss_rd_wen  in  1  instruction writes rd
- iss_long  in  1  result returns via LSU path
- iss_stall  out  1  issue blocked this cycle
- alu_wb_valid, alu_wb_rd, alu_wb_data  in  1/5/32  ALU writeback (no backpressure)
- lsu_wb_valid, lsu_wb_rd, lsu_wb_data  in  1/5/32  LSU writeback request
- lsu_wb_ready  out  1  LSU request accepted this cycle
- rf_wen, rf_wadd, rf_wdata  out  1/5/32  to regfile write port
- busy_vec  out  32  registered busy bits (debug)
- wb_err  out  1  sticky: write committed to a non-busy register

## Operation
- State: busy[31:1] (busy[0] is hardwired 0), long_cnt[CNT_W-1:0], and wb_err.
- Hazard condition: iss_stall = iss_valid & (RAW | WAW | LIM).
  - RAW: (use_rs1 & busy[rs1]) | (use_rs2 & busy[rs2]).
  - WAW: rd_wen & busy[rd].
  - LIM: iss_long & (long_cnt == MAX_LONG).
  - All three terms use registered state only; there is no same-cycle bypass.
- Issue acceptance: issue is accepted when iss_valid & !iss_stall & !pipe_stall.
  - On acceptance, if rd_wen and rd != 0, busy[rd] is set.
  - On acceptance, if iss_long, long_cnt increments.
- Arbitration:
  - The ALU has fixed priority.
  - lsu_wb_ready = lsu_wb_valid & !alu_wb_valid & !pipe_stall.
  - The LSU must hold valid/rd/data stable until it sees ready.
- Write port output: rf_wen/rf_wadd/rf_wdata select the ALU inputs if alu_wb_valid, else the LSU inputs; otherwise rf_wen = 0. These outputs are combinational.
- Commit: a write commits when rf_wen & !pipe_stall.
  - A commit clears busy[rf_wadd].
  - An LSU commit decrements long_cnt.
- Simultaneous set and clear of the same register: set wins. The register stays busy because a new writer is now pending.
- Simultaneous long_cnt increment and decrement: long_cnt is unchanged.
- Error detection: wb_err is set if a commit targets rf_wadd != 0 with busy[rf_wadd] == 0. Writes to x0 are passed through and do not set wb_err.
- Reset: busy = 0, long_cnt = 0, wb_err = 0.
- Reset mid-operation: all pending writes are forgotten immediately. Requesters are reset by the same RSTn.

## Timing
- Reset values: iss_stall = 0, lsu_wb_ready = 0, rf_wen = 0, busy_vec = 0, wb_err = 0. All outputs are 0 while RSTn is low and no requests are present.
- Busy latency:
  - Busy sets at the edge that accepts the issue.
  - A dependent instruction presented in the next cycle stalls.
- Release latency:
  - A commit at edge N clears busy at edge N.
  - A dependent instruction issues in cycle N+1.
  - The regfile read at edge N+1 returns the new value (one-cycle bubble, intended).
- LSU blocked: while alu_wb_valid is held high, the LSU waits indefinitely. No fairness is required, because the ALU issues at most one write per issued instruction.
- Stalled pipeline: during pipe_stall, rf_wen may be high, but nothing commits and no issue is accepted. All state holds.

## Structure
- Shared package (the pipeline package): REG_IDX_W = 5, XLEN = 32, NUM_REGS = 32.
- Sub-module: `rf_wb_arb`, the combinational two-way priority mux that produces lsu_wb_ready and rf_w*. Busy and counter logic stay in the top level.

## Test plan
- Reset with RSTn = 0 mid-stream: busy_vec = 0, long_cnt = 0, and all outputs 0. After release, an issue with rs1 = 5 proceeds with no stall.
- Issue rd = 3 (ALU), then next cycle rs1 = 3 → iss_stall = 1. ALU commit rd = 3 with data 0xDEADBEEF → stall drops the following cycle, and the regfile reads 0xDEADBEEF.
- Same-cycle conflict: alu_wb_valid (rd = 4) and lsu_wb_valid (rd = 7) together → rf_wadd = 4 and lsu_wb_ready = 0. In the next cycle rf_wadd = 7 and lsu_wb_ready = 1; both busy bits end clear.
- MAX_LONG = 2: two long issues are accepted, and the third long issue stalls (LIM). One LSU commit → the third issue is accepted in the next cycle, with long_cnt = 2.
- Commit rd = 9 while issuing a new rd = 9 in the same cycle → busy[9] remains 1. rd = 0 issue/commit → busy_vec unchanged and wb_err = 0.
- pipe_stall = 1 with an ALU write pending → busy is unchanged and lsu_wb_ready = 0. A spurious commit to non-busy rd = 12 → wb_err = 1, and it stays sticky until reset.
